// File: rtl/exec_pkg.sv
// Shared types for the shift execution stage: operation encoding, request bundle
// and the bit-reversal helper used to build left shifts from a right shifter.
package exec_pkg;

  localparam int EXEC_XLEN = 32;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_RSVD = 2'b10,
    OP_SRA  = 2'b11
  } shift_op_t;

  typedef struct packed {
    shift_op_t            op;
    logic [EXEC_XLEN-1:0] a;
    logic [4:0]           shamt;
    logic [4:0]           rd;
  } shift_req_t;

  function automatic logic [EXEC_XLEN-1:0] bit_reverse(input logic [EXEC_XLEN-1:0] v);
    logic [EXEC_XLEN-1:0] r;
    for (int i = 0; i < EXEC_XLEN; i++) begin
      r[i] = v[EXEC_XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational right shifter (logical or arithmetic) covering shift levels
// LVL_HI down to LVL_LO; shamt_i carries only the bits for those levels.
module shift_core #(
  parameter int XLEN   = 32,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 4
) (
  input  logic [XLEN-1:0]        data_i,
  input  logic [LVL_HI-LVL_LO:0] shamt_i,
  input  logic                   arith_i,
  output logic [XLEN-1:0]        data_o
);

  localparam int NLVL = LVL_HI - LVL_LO + 1;

  logic [XLEN-1:0] lvl_w [NLVL+1];
  logic            fill;

  // An arithmetic shift keeps the sign in the MSB, so a later partial stage can
  // take its fill bit from its own input.
  assign fill     = arith_i & data_i[XLEN-1];
  assign lvl_w[0] = data_i;

  genvar gi;
  generate
    for (gi = 0; gi < NLVL; gi++) begin : g_level
      localparam int AMT = 1 << (LVL_HI - gi);
      assign lvl_w[gi+1] = shamt_i[NLVL-1-gi]
                         ? {{AMT{fill}}, lvl_w[gi][XLEN-1:AMT]}
                         : lvl_w[gi];
    end
  endgenerate

  assign data_o = lvl_w[NLVL];

endmodule

// File: rtl/shift_exec_stage.sv
// Shift execution stage with valid/ready handshake and flush. Optional macro
// SHIFT_EXEC_PIPE_EN splits the shifter into two slots (latency 2 instead of 1).
module shift_exec_stage
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [4:0]      in_shamt,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  shift_req_t      req;
  logic [XLEN-1:0] pre_shift;
  logic            accept;
  logic            out_free;
  logic            load_out;
  logic            load_sll;
  logic            load_illegal;
  logic [4:0]      load_rd;
  logic [XLEN-1:0] load_shifted;

  logic            out_valid_q;
  logic [XLEN-1:0] out_result_q;
  logic [XLEN-1:0] out_result_d;
  logic [4:0]      out_rd_q;
  logic            out_illegal_q;

  assign req       = '{op: shift_op_t'(in_op), a: in_a, shamt: in_shamt, rd: in_rd};
  assign pre_shift = (req.op == OP_SLL) ? bit_reverse(req.a) : req.a;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;

`ifdef SHIFT_EXEC_PIPE_EN
  logic            s1_valid_q;
  logic [XLEN-1:0] s1_data_q;
  logic [XLEN-1:0] s1_data_d;
  logic [2:0]      s1_shamt_q;
  logic [4:0]      s1_rd_q;
  logic            s1_sll_q;
  logic            s1_sra_q;
  logic            s1_illegal_q;
  logic            s1_advance;

  shift_core #(.XLEN(XLEN), .LVL_LO(3), .LVL_HI(4)) u_core_hi (
    .data_i  (pre_shift),
    .shamt_i (req.shamt[4:3]),
    .arith_i (req.op == OP_SRA),
    .data_o  (s1_data_d)
  );

  // Slot 1 moves on whenever slot 2 is empty or draining this cycle.
  assign s1_advance = s1_valid_q && out_free;
  assign in_ready   = !rst && (!s1_valid_q || out_free);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
    end else if (s1_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data_q    <= s1_data_d;
      s1_shamt_q   <= req.shamt[2:0];
      s1_rd_q      <= req.rd;
      s1_sll_q     <= (req.op == OP_SLL);
      s1_sra_q     <= (req.op == OP_SRA);
      s1_illegal_q <= (req.op == OP_RSVD);
    end
  end

  shift_core #(.XLEN(XLEN), .LVL_LO(0), .LVL_HI(2)) u_core_lo (
    .data_i  (s1_data_q),
    .shamt_i (s1_shamt_q),
    .arith_i (s1_sra_q),
    .data_o  (load_shifted)
  );

  assign load_out     = s1_advance;
  assign load_sll     = s1_sll_q;
  assign load_illegal = s1_illegal_q;
  assign load_rd      = s1_rd_q;
`else
  shift_core #(.XLEN(XLEN), .LVL_LO(0), .LVL_HI(4)) u_core (
    .data_i  (pre_shift),
    .shamt_i (req.shamt),
    .arith_i (req.op == OP_SRA),
    .data_o  (load_shifted)
  );

  assign in_ready     = !rst && out_free;
  assign load_out     = accept;
  assign load_sll     = (req.op == OP_SLL);
  assign load_illegal = (req.op == OP_RSVD);
  assign load_rd      = req.rd;
`endif

  assign out_result_d = load_illegal ? '0
                      : (load_sll ? bit_reverse(load_shifted) : load_shifted);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid_q   <= 1'b0;
    end else if (load_out) begin
      out_valid_q   <= 1'b1;
      out_result_q  <= out_result_d;
      out_rd_q      <= load_rd;
      out_illegal_q <= load_illegal;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; only 32 supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  kill all in-flight ops (branch mispredict/trap).
REQ-005 in_valid  input  1  issue op valid.
REQ-006 in_ready  output  1  stage can accept op this cycle.
REQ-007 in_op  input  2  shift_op_t: SLL=00, SRL=01, SRA=11, 10 reserved.
REQ-008 in_a  input  32  value to shift (rs1).
REQ-009 in_shamt  input  5  shift amount (rs2[4:0] or imm[4:0]).
REQ-010 in_rd  input  5  destination register tag.
REQ-011 out_valid  output  1  result valid to writeback.
REQ-012 out_ready  input  1  writeback accepts result.
REQ-013 out_result  output  32  shifted value.
REQ-014 out_rd  output  5  tag of out_result.
REQ-015 out_illegal  output  1  op was reserved encoding 10.

Function
REQ-016 Transfer occurs on input when in_valid&&in_ready, on output when out_valid&&out_ready, both sampled at rising edge.
REQ-017 Each pipeline slot is EMPTY or FULL; EMPTY->FULL on accept, FULL->EMPTY on drain with no new accept, FULL->FULL on simultaneous drain+accept.
REQ-018 in_ready = !rst && (output slot EMPTY || out_ready); full throughput of one op/cycle with out_ready held high.
REQ-019 Latency in->out is 1 cycle (macro off) or 2 cycles (macro on), measured accept edge to out_valid high.
REQ-020 SLL: in_a << shamt, zero fill; implemented as bit-reverse, logical right shift, bit-reverse.
REQ-021 SRL: in_a >> shamt, zero fill; SRA: fill with in_a[31].
REQ-022 shamt 0 returns in_a unchanged for all ops; shamt 31 returns bit 0 (SLL), bit 31 (SRL/SRA) positioned correctly.
REQ-023 Reserved op: out_result=0, out_illegal=1, otherwise handled as a normal op (consumes slot, same latency).
REQ-024 While out_valid&&!out_ready, out_result/out_rd/out_illegal held stable; no op lost or duplicated.
REQ-025 flush: all slots EMPTY next cycle; flush wins over a same-cycle accept (op discarded); in_ready unaffected by flush.
REQ-026 in_rd=0 ops flow normally; writeback discards x0 writes.

Reset
REQ-027 rst high: all slots EMPTY, out_valid=0, out_result=0, out_rd=0, out_illegal=0, in_ready=0.
REQ-028 First cycle after rst deasserts: in_ready=1.
REQ-029 rst mid-operation discards all in-flight ops with no output handshake; rst has priority over flush and accept.

Configuration
REQ-030 Macro SHIFT_EXEC_PIPE_EN defined: extra register after the first 16/8 shift levels, 2-slot pipeline, latency 2, backpressure propagates slot-by-slot (a bubble in slot 2 lets slot 1 advance).
REQ-031 Macro undefined: single output slot, full shift in one cycle, latency 1.
REQ-032 Function, ordering, reset and flush behaviour identical in both builds except latency.

Structure
REQ-033 exec_pkg holds shift_op_t enum, XLEN constant and a shift request struct (op, a, shamt, rd).
REQ-034 Combinational right-shift datapath in sub-module shift_core (in, shamt, arith -> out), two instances' worth of levels split at stage boundary when pipelined.
REQ-035 shift_exec_stage owns all handshake, slot registers and bit-reversal.

Verification
REQ-036 SLL a=0x0000_0001 shamt=31 -> out_result=0x8000_0000, out_rd echoed, out_illegal=0.
REQ-037 SRA a=0x8000_00F0 shamt=4 -> 0xF800_000F; SRL same inputs -> 0x0800_000F.
REQ-038 Back-to-back 8 ops, out_ready=1 -> 8 results in order, one per cycle, latency 1 (2 with macro).
REQ-039 out_ready=0 for 5 cycles with output FULL -> out_* stable, in_ready=0 (macro off) after pipeline fills; release -> no loss.
REQ-040 flush same cycle as accept of op rd=7 -> op rd=7 never appears; out_valid=0 next cycle.
REQ-041 op=10, a=0xFFFF_FFFF -> out_result=0, out_illegal=1; rst pulse mid-stream -> out_valid=0 following cycle, in_ready=1 after release.
